// File: rtl/qfb_pkg.sv
// Shared types and helpers for the quantised feature buffer.
package qfb_pkg;

    // Sequencer states: held in reset, zero-filling, or serving reads and writes.
    typedef enum logic [1:0] {
        RESET_ST = 2'd0,
        CLEAR    = 2'd1,
        READY    = 2'd2
    } qfb_state_e;

    // Even-parity bit for a zero-extended word: 1 when the word has an odd number of ones.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

    // Address width for a given depth; never narrower than one bit.
    function automatic int unsigned qfb_clog2(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/qfb_clear_fsm.sv
// Clear sequencer: walks the array from address 0 to DEPTH-1 after reset or on request,
// and reports when the array is available for normal traffic.
module qfb_clear_fsm
    import qfb_pkg::*;
#(
    parameter int unsigned DEPTH          = 4096,
    parameter int unsigned ADDR_W         = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    qfb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and clear-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_ST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and clear-write strobe. Address 0 is cleared on the first cycle out of
    // reset so that ready rises exactly DEPTH cycles after release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            RESET_ST: begin
                if (CLEAR_ON_RESET) begin
                    clr_we = 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = READY;
                    end else begin
                        state_d = CLEAR;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = READY;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = RESET_ST;
        endcase
        if (rst) begin
            clr_we = 1'b0;
        end
    end

    assign ready    = (state_q == READY);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/quant_feature_buffer.sv
// Multi-read feature store with built-in zero-fill sequencer.
// Optional feature: define QFB_PARITY_EN to store an even-parity bit per word and flag
// parity errors on every valid read.
module quant_feature_buffer
    import qfb_pkg::*;
#(
    parameter int unsigned DATA_W         = 6,
    parameter int unsigned DEPTH          = 4096,
    parameter int unsigned NUM_RD         = 2,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned ADDR_W        = qfb_clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_req,
    output logic                     ready,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
`ifdef QFB_PARITY_EN
    output logic [NUM_RD-1:0]        parity_err,
    input  logic                     inj_par_err,
`endif
    output logic [NUM_RD-1:0]        rd_valid
);

`ifdef QFB_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic [WORD_W-1:0] wr_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_word;

    logic [ADDR_W-1:0] rd_addr_a [NUM_RD];
    logic [WORD_W-1:0] rd_word   [NUM_RD];
    logic [DATA_W-1:0] rd_data_q [NUM_RD];
    logic [NUM_RD-1:0] rd_valid_q;

    qfb_clear_fsm #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .ready     (ready),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

`ifdef QFB_PARITY_EN
    assign wr_word = {even_parity(32'(wr_data)) ^ inj_par_err, wr_data};
`else
    assign wr_word = wr_data;
`endif

    // A user write needs READY, loses to a same-cycle clear request, and is dropped when
    // out of range.
    assign user_we = ready && !rst && wr_en && !clear_req && (32'(wr_addr) < DEPTH);

    // Write mux; the clear sequencer only runs while ready is low, so the two never collide.
    always_comb begin
        mem_we   = clr_we | user_we;
        mem_addr = clr_we ? clr_addr : wr_addr;
        mem_word = clr_we ? '0 : wr_word;
    end

    // Storage array; zero word carries correct even parity.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_word;
        end
    end

    // Per-port lookup with write-first bypass; out-of-range reads return zero.
    always_comb begin
        for (int i = 0; i < int'(NUM_RD); i++) begin
            rd_addr_a[i] = rd_addr[i*ADDR_W +: ADDR_W];
            rd_word[i]   = '0;
            if (32'(rd_addr_a[i]) < DEPTH) begin
                if (user_we && (wr_addr == rd_addr_a[i])) begin
                    rd_word[i] = wr_word;
                end else begin
                    rd_word[i] = mem[rd_addr_a[i]];
                end
            end
        end
    end

    // Read output registers; data holds when a port is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= '0;
`ifdef QFB_PARITY_EN
            parity_err <= '0;
`endif
            for (int i = 0; i < int'(NUM_RD); i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_RD); i++) begin
                if (ready && rd_en[i]) begin
                    rd_valid_q[i] <= 1'b1;
                    rd_data_q[i]  <= rd_word[i][DATA_W-1:0];
`ifdef QFB_PARITY_EN
                    parity_err[i] <= even_parity(32'(rd_word[i]));
`endif
                end else begin
                    rd_valid_q[i] <= 1'b0;
`ifdef QFB_PARITY_EN
                    parity_err[i] <= 1'b0;
`endif
                end
            end
        end
    end

    // Pack per-port registers onto the flat output bus.
    always_comb begin
        for (int i = 0; i < int'(NUM_RD); i++) begin
            rd_data[i*DATA_W +: DATA_W] = rd_data_q[i];
        end
    end

    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_quant_feature_buffer.sv
// Self-checking bench for quant_feature_buffer: directed steps plus randomized traffic
// checked against an array-based reference model.
module tb_quant_feature_buffer;

    localparam int unsigned DATA_W = 6;
    localparam int unsigned DEPTH  = 12;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned ADDR_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: DEPTH=12, two read ports, clear after reset.
    logic                     rst = 1'b1;
    logic                     clear_req = 1'b0;
    logic                     ready;
    logic                     wr_en = 1'b0;
    logic [ADDR_W-1:0]        wr_addr = '0;
    logic [DATA_W-1:0]        wr_data = '0;
    logic [NUM_RD-1:0]        rd_en = '0;
    logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;

    // Second DUT: DEPTH=16, one read port, ready straight out of reset.
    logic              nc_ready;
    logic              nc_wr_en = 1'b0;
    logic [3:0]        nc_wr_addr = '0;
    logic [DATA_W-1:0] nc_wr_data = '0;
    logic [0:0]        nc_rd_en = '0;
    logic [3:0]        nc_rd_addr = '0;
    logic [DATA_W-1:0] nc_rd_data;
    logic [0:0]        nc_rd_valid;

`ifdef QFB_PARITY_EN
    logic              inj_par_err = 1'b0;
    logic [NUM_RD-1:0] parity_err;
    logic [0:0]        nc_parity_err;
`endif

    quant_feature_buffer #(
        .DATA_W         (DATA_W),
        .DEPTH          (DEPTH),
        .NUM_RD         (NUM_RD),
        .CLEAR_ON_RESET (1'b1)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .clear_req   (clear_req),
        .ready       (ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
`ifdef QFB_PARITY_EN
        .parity_err  (parity_err),
        .inj_par_err (inj_par_err),
`endif
        .rd_valid    (rd_valid)
    );

    quant_feature_buffer #(
        .DATA_W         (DATA_W),
        .DEPTH          (16),
        .NUM_RD         (1),
        .CLEAR_ON_RESET (1'b0)
    ) u_dut_nc (
        .clk         (clk),
        .rst         (rst),
        .clear_req   (1'b0),
        .ready       (nc_ready),
        .wr_en       (nc_wr_en),
        .wr_addr     (nc_wr_addr),
        .wr_data     (nc_wr_data),
        .rd_en       (nc_rd_en),
        .rd_addr     (nc_rd_addr),
        .rd_data     (nc_rd_data),
`ifdef QFB_PARITY_EN
        .parity_err  (nc_parity_err),
        .inj_par_err (1'b0),
`endif
        .rd_valid    (nc_rd_valid)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: array contents, per-word injected-parity flag, and ready countdown.
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_bad [DEPTH];
    bit                m_ready = 1'b0;
    int                m_wait  = int'(DEPTH);
    logic [DATA_W-1:0] e_data  [NUM_RD];
    logic [NUM_RD-1:0] e_valid = '0;
    logic [NUM_RD-1:0] e_perr  = '0;

    task automatic set_rd(input int p, input int a);
        rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    // Predict one clock edge from the current inputs, advance, then compare.
    task automatic cycle();
        int a;
        int wa;
        bit inj;
        inj = 1'b0;
`ifdef QFB_PARITY_EN
        inj = inj_par_err;
`endif
        wa = int'(wr_addr);
        if (rst) begin
            m_ready = 1'b0;
            m_wait  = int'(DEPTH);
            e_valid = '0;
            e_perr  = '0;
            for (int p = 0; p < int'(NUM_RD); p++) e_data[p] = '0;
        end else if (m_ready) begin
            for (int p = 0; p < int'(NUM_RD); p++) begin
                a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
                e_perr[p] = 1'b0;
                if (!rd_en[p]) begin
                    e_valid[p] = 1'b0;
                end else begin
                    e_valid[p] = 1'b1;
                    if (a >= int'(DEPTH)) begin
                        e_data[p] = '0;
                    end else if (wr_en && !clear_req && wa == a) begin
                        e_data[p] = wr_data;
                        e_perr[p] = inj;
                    end else begin
                        e_data[p] = m_mem[a];
                        e_perr[p] = m_bad[a];
                    end
                end
            end
            if (clear_req) begin
                m_ready = 1'b0;
                m_wait  = int'(DEPTH);
            end else if (wr_en && wa < int'(DEPTH)) begin
                m_mem[wa] = wr_data;
                m_bad[wa] = inj;
            end
        end else begin
            // Array is being zero-filled; all traffic ignored.
            e_valid = '0;
            e_perr  = '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                m_mem[k] = '0;
                m_bad[k] = 1'b0;
            end
            m_wait--;
            if (m_wait == 0) m_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("ready", ready, m_ready);
        for (int p = 0; p < int'(NUM_RD); p++) begin
            check($sformatf("rd_valid[%0d]", p), rd_valid[p], e_valid[p]);
            check($sformatf("rd_data[%0d]", p), rd_data[p*DATA_W +: DATA_W], e_data[p]);
`ifdef QFB_PARITY_EN
            check($sformatf("parity_err[%0d]", p), parity_err[p], e_perr[p]);
`endif
        end
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        rd_en     = '0;
        clear_req = 1'b0;
`ifdef QFB_PARITY_EN
        inj_par_err = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            m_mem[k] = '0;
            m_bad[k] = 1'b0;
        end
        for (int p = 0; p < int'(NUM_RD); p++) e_data[p] = '0;

        // Reset values on both instances.
        cycle();
        cycle();
        check("nc_ready_in_reset", nc_ready, 1'b0);
        check("nc_valid_in_reset", nc_rd_valid, 1'b0);
        check("nc_data_in_reset", nc_rd_data, 6'h00);

        // Release: no-clear instance is ready at once; main instance after DEPTH cycles.
        rst = 1'b0;
        cycle();
        check("nc_ready_first_cycle", nc_ready, 1'b1);
        repeat (DEPTH - 1) cycle();

        // Preload all-ones, reset, and confirm the clear wipes them.
        for (int a = 0; a < int'(DEPTH); a++) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(a);
            wr_data = '1;
            cycle();
        end
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        repeat (DEPTH) cycle();
        for (int a = 0; a < int'(DEPTH); a++) begin
            rd_en = '1;
            set_rd(0, a);
            set_rd(1, int'(DEPTH) - 1 - a);
            cycle();
        end
        idle();

        // Write then read on both ports next cycle.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 6'h2A;
        cycle();
        wr_en = 1'b0; rd_en = 2'b11; set_rd(0, 5); set_rd(1, 5);
        cycle();
        check("rd5_port0", rd_data[5:0], 6'h2A);
        check("rd5_port1", rd_data[11:6], 6'h2A);
        rd_en = 2'b00;
        cycle();
        check("idle_holds_data", rd_data[11:6], 6'h2A);

        // Same-cycle write and read: write-first.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 6'h11;
        rd_en = 2'b11; set_rd(0, 5); set_rd(1, 7);
        cycle();
        check("bypass_port1", rd_data[11:6], 6'h11);
        idle();

        // Out-of-range write is dropped; out-of-range read is zero but valid.
        wr_en = 1'b1; wr_addr = 4'd13; wr_data = 6'h3C;
        cycle();
        wr_en = 1'b0; rd_en = 2'b01; set_rd(0, 13);
        cycle();
        check("oor_valid", rd_valid[0], 1'b1);
        check("oor_data", rd_data[5:0], 6'h00);
        for (int a = 0; a < int'(DEPTH); a++) begin
            rd_en = 2'b11; set_rd(0, a); set_rd(1, 15);
            cycle();
        end
        idle();

        // Clear request beats a same-cycle write; traffic during the clear is ignored.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 6'h07; clear_req = 1'b1;
        cycle();
        check("clear_drops_ready", ready, 1'b0);
        repeat (DEPTH) begin
            wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = 6'($urandom);
            rd_en = 2'($urandom); rd_addr = 8'($urandom); clear_req = 1'($urandom);
            cycle();
        end
        idle();
        rd_en = 2'b11; set_rd(0, 3); set_rd(1, 5);
        cycle();
        check("clear_won_addr3", rd_data[5:0], 6'h00);
        idle();

        // Reset in the middle of a clear restarts the full sequence.
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 6'h2B;
        cycle();
        idle();
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        repeat (6) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (DEPTH) cycle();
        check("ready_after_midclear_reset", ready, 1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wr_en     = 1'($urandom);
            wr_addr   = 4'($urandom);
            wr_data   = 6'($urandom);
            rd_en     = 2'($urandom);
            rd_addr   = 8'($urandom);
            clear_req = ($urandom_range(0, 49) == 0);
`ifdef QFB_PARITY_EN
            inj_par_err = ($urandom_range(0, 7) == 0);
`endif
            cycle();
        end
        idle();
        repeat (DEPTH + 1) cycle();

        // No-clear instance: full-range write and read, then hold.
        nc_wr_en = 1'b1; nc_wr_addr = 4'd15; nc_wr_data = 6'h3F;
        cycle();
        nc_wr_en = 1'b0; nc_rd_en = 1'b1; nc_rd_addr = 4'd15;
        cycle();
        check("nc_rd15_valid", nc_rd_valid, 1'b1);
        check("nc_rd15_data", nc_rd_data, 6'h3F);
        nc_rd_en = 1'b0;
        cycle();
        check("nc_idle_valid", nc_rd_valid, 1'b0);
        check("nc_idle_data", nc_rd_data, 6'h3F);

`ifdef QFB_PARITY_EN
        // Injected parity error is flagged; a clean rewrite clears it.
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 6'h15; inj_par_err = 1'b1;
        cycle();
        idle();
        rd_en = 2'b01; set_rd(0, 2);
        cycle();
        check("par_inj_flagged", parity_err[0], 1'b1);
        idle();
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 6'h15;
        cycle();
        idle();
        rd_en = 2'b01; set_rd(0, 2);
        cycle();
        check("par_clean", parity_err[0], 1'b0);
        idle();
        cycle();
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
